// File: rtl/multi_edge_pulse_if.sv
// multi_edge_pulse_if: event-pulse bundle (raw inputs, modes, pulses, levels).
// master drives sig_in/mode; slave (the block) drives sig_out/level_out.
interface multi_edge_pulse_if #(
  parameter int N = 4
);
  logic [N-1:0]   sig_in;
  logic [2*N-1:0] mode;
  logic [N-1:0]   sig_out;
  logic [N-1:0]   level_out;

  modport master (
    output sig_in,
    output mode,
    input  sig_out,
    input  level_out
  );

  modport slave (
    input  sig_in,
    input  mode,
    output sig_out,
    output level_out
  );
endinterface

// File: rtl/multi_edge_pulse.sv
// multi_edge_pulse: per-channel sync + debounce + mode-gated edge one-shot.
// Ports: clk, rst_n (async low), bus (sig_in, mode in; sig_out, level_out out).
module multi_edge_pulse #(
  parameter int N               = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_LEN       = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  multi_edge_pulse_if.slave   bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(PULSE_LEN + 1);
  localparam logic [CW-1:0] CMAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PLOAD = PW'(PULSE_LEN);

  logic [N-1:0] level_q;
  logic [N-1:0] pulse_q;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic [PW-1:0]          pcnt;
    logic                   s;
    logic                   flip;
    logic                   qual;

    assign s    = sync[SYNC_STAGES-1];
    // level accepts s on this edge
    assign flip = (s != level_q[i]) && (cnt == CMAX);
    assign qual = flip && (s ? bus.mode[2*i] : bus.mode[2*i+1]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync       <= '0;
        cnt        <= '0;
        level_q[i] <= 1'b0;
        pcnt       <= '0;
        pulse_q[i] <= 1'b0;
      end else begin
        sync[0] <= bus.sig_in[i];
        for (int k = 1; k < SYNC_STAGES; k++) begin
          sync[k] <= sync[k-1];
        end

        if (s == level_q[i]) begin
          cnt <= '0;
        end else if (cnt == CMAX) begin
          level_q[i] <= s;
          cnt        <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end

        // reload on every qualified edge so overlaps merge
        if (qual) begin
          pcnt <= PLOAD;
        end else if (pcnt != '0) begin
          pcnt <= pcnt - 1'b1;
        end

        pulse_q[i] <= (pcnt != '0);
      end
    end
  end

  assign bus.sig_out   = pulse_q;
  assign bus.level_out = level_q;

endmodule

// File: tb/tb_multi_edge_pulse.sv
// tb_multi_edge_pulse: directed vectors, per-edge scoreboard for four configs.
// Edge 0 of a test is the clock edge right before the input change.
module tb_multi_edge_pulse;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst_n_v;

  multi_edge_pulse_if #(.N(4)) bus_a ();
  multi_edge_pulse_if #(.N(4)) bus_b ();
  multi_edge_pulse_if #(.N(4)) bus_c ();
  multi_edge_pulse_if #(.N(4)) bus_d ();

  multi_edge_pulse #(.N(4)) dut_a (
    .clk(clk), .rst_n(rst_n_v[0]), .bus(bus_a)
  );
  multi_edge_pulse #(.N(4), .PULSE_LEN(3)) dut_b (
    .clk(clk), .rst_n(rst_n_v[1]), .bus(bus_b)
  );
  multi_edge_pulse #(
    .N(4), .DEBOUNCE_CYCLES(2), .PULSE_LEN(10)
  ) dut_c (
    .clk(clk), .rst_n(rst_n_v[2]), .bus(bus_c)
  );
  multi_edge_pulse #(.N(4), .PULSE_LEN(8)) dut_d (
    .clk(clk), .rst_n(rst_n_v[3]), .bus(bus_d)
  );

  logic [3:0] so_v [4];
  logic [3:0] lo_v [4];
  assign so_v[0] = bus_a.sig_out;
  assign so_v[1] = bus_b.sig_out;
  assign so_v[2] = bus_c.sig_out;
  assign so_v[3] = bus_d.sig_out;
  assign lo_v[0] = bus_a.level_out;
  assign lo_v[1] = bus_b.level_out;
  assign lo_v[2] = bus_c.level_out;
  assign lo_v[3] = bus_d.level_out;

  typedef struct {
    int         id;
    int         edge_no;
    logic [3:0] so;
    logic [3:0] lo;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   edge_n = 0;
  int   n_vec  = 0;
  int   n_err  = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].edge_no <= edge_n) begin
      mon_e = q.pop_front();
      n_vec++;
      if (mon_e.edge_no != edge_n) begin
        n_err++;
        $display("FAIL %s dut%0d: stale entry edge %0d at edge %0d",
                 mon_e.name, mon_e.id, mon_e.edge_no, edge_n);
      end else if (so_v[mon_e.id] !== mon_e.so ||
                   lo_v[mon_e.id] !== mon_e.lo) begin
        n_err++;
        $display({"FAIL %s dut%0d edge %0d: sig_out=%b level_out=%b,",
                  " expected sig_out=%b level_out=%b"},
                 mon_e.name, mon_e.id, mon_e.edge_no,
                 so_v[mon_e.id], lo_v[mon_e.id], mon_e.so, mon_e.lo);
      end
    end
  end

  task automatic push(input int id, input string nm,
                      input logic [3:0] so, input logic [3:0] lo);
    exp_t e;
    e.id      = id;
    e.edge_no = edge_n;
    e.so      = so;
    e.lo      = lo;
    e.name    = nm;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    bus_a.sig_in = '0; bus_a.mode = '0;
    bus_b.sig_in = '0; bus_b.mode = '0;
    bus_c.sig_in = '0; bus_c.mode = '0;
    bus_d.sig_in = '0; bus_d.mode = '0;
  endtask

  task automatic do_reset();
    tick();
    clr_inputs();
    rst_n_v = 4'h0;
    for (int i = 0; i < 4; i++) push(i, "reset", 4'h0, 4'h0);
    tick();
    for (int i = 0; i < 4; i++) push(i, "reset", 4'h0, 4'h0);
    rst_n_v = 4'hF;
  endtask

  initial begin
    rst_n_v = 4'h0;
    clr_inputs();
    do_reset();

    // 1: clean rise, ch0 mode 01
    bus_a.mode = 8'b00_00_00_01;
    tick();
    bus_a.sig_in[0] = 1'b1;
    for (int e = 0; e <= 12; e++) begin
      if (e > 0) tick();
      push(0, "clean_rise",
           {3'b000, (e == 7)}, {3'b000, (e >= 6)});
    end

    // 2: 3-cycle glitch on ch1, mode 11
    do_reset();
    bus_a.mode = 8'b00_00_11_00;
    tick();
    bus_a.sig_in[1] = 1'b1;
    for (int e = 0; e <= 15; e++) begin
      if (e > 0) tick();
      if (e == 3) bus_a.sig_in[1] = 1'b0;
      push(0, "glitch", 4'h0, 4'h0);
    end

    // 3: both edges, PULSE_LEN=3, ch2
    do_reset();
    bus_b.mode = 8'b00_11_00_00;
    tick();
    bus_b.sig_in[2] = 1'b1;
    for (int e = 0; e <= 35; e++) begin
      if (e > 0) tick();
      if (e == 20) bus_b.sig_in[2] = 1'b0;
      push(1, "both_edges",
           {1'b0, ((e >= 7 && e < 10) || (e >= 27 && e < 30)), 2'b00},
           {1'b0, (e >= 6 && e < 26), 2'b00});
    end

    // 4: retrigger, DEBOUNCE_CYCLES=2, PULSE_LEN=10
    do_reset();
    bus_c.mode = 8'b00_00_00_11;
    tick();
    bus_c.sig_in[0] = 1'b1;
    for (int e = 0; e <= 25; e++) begin
      if (e > 0) tick();
      if (e == 5) bus_c.sig_in[0] = 1'b0;
      push(2, "retrigger",
           {3'b000, (e >= 5 && e < 20)},
           {3'b000, (e >= 4 && e < 9)});
    end

    // 5: mode gating across all channels
    do_reset();
    bus_a.mode = 8'b11_10_01_00;
    tick();
    bus_a.sig_in = 4'hF;
    for (int e = 0; e <= 25; e++) begin
      logic [3:0] so_x;
      if (e > 0) tick();
      if (e == 12) bus_a.sig_in = 4'h0;
      so_x = (e == 7)  ? 4'b1010 :
             (e == 19) ? 4'b1100 : 4'b0000;
      push(0, "mode_gate", so_x,
           (e >= 6 && e < 18) ? 4'hF : 4'h0);
    end

    // 6: async reset mid-pulse, PULSE_LEN=8, input held high
    do_reset();
    bus_d.mode = 8'b00_00_00_01;
    tick();
    bus_d.sig_in[0] = 1'b1;
    for (int e = 0; e <= 30; e++) begin
      if (e > 0) tick();
      if (e == 9)  rst_n_v[3] = 1'b0;
      if (e == 11) rst_n_v[3] = 1'b1;
      if (e >= 9 && e <= 11) begin
        push(3, "rst_mid_pulse", 4'h0, 4'h0);
      end else if (e < 9) begin
        push(3, "pre_rst_pulse",
             {3'b000, (e >= 7)}, {3'b000, (e >= 6)});
      end else begin
        push(3, "rst_repulse",
             {3'b000, (e >= 18 && e < 26)},
             {3'b000, (e >= 17)});
      end
    end

    tick();
    tick();
    if (q.size() != 0) begin
      n_err += q.size();
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
